// File: rtl/solar_sample_averager.sv
// Block-averages interleaved voltage/current ADC samples over 2^LOG2_AVG samples per channel and emits avg_v, avg_i, avg_v*avg_i.
// Optional SOLAR_AVG_MINMAX_EN adds per-window voltage min/max outputs.
module solar_sample_averager #(
   parameter int SAMPLE_W = 12,
   parameter int LOG2_AVG = 4
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic                    s_chan,
   input  logic [SAMPLE_W-1:0]     s_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [SAMPLE_W-1:0]     m_avg_v,
   output logic [SAMPLE_W-1:0]     m_avg_i,
   output logic [2*SAMPLE_W-1:0]   m_power,
`ifdef SOLAR_AVG_MINMAX_EN
   output logic [SAMPLE_W-1:0]     m_min_v,
   output logic [SAMPLE_W-1:0]     m_max_v,
`endif
   output logic                    ovf,
   input  logic                    clr_ovf
);

   localparam int ACC_W = SAMPLE_W + LOG2_AVG;
   localparam int CNT_W = LOG2_AVG + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(2 ** LOG2_AVG);

   typedef enum logic {ACCUM, MUL} state_t;
   state_t state, state_nx;

   logic [ACC_W-1:0]      acc_v, acc_i, sum_v, sum_i;
   logic [CNT_W-1:0]      cnt_v, cnt_i, cnt_v_nx, cnt_i_nx;
   logic [SAMPLE_W-1:0]   avg_v, avg_i;
   logic [2*SAMPLE_W-1:0] prod;
   logic                  full_v, full_i, hs, take_v, take_i, done;

   assign full_v = (cnt_v == FULL_CNT);
   assign full_i = (cnt_i == FULL_CNT);
   // ready depends on s_chan so a sample for a full channel stalls until the other fills
   assign s_ready = (state == ACCUM) && !(s_chan ? full_i : full_v);
   assign hs      = s_valid & s_ready;
   assign take_v  = hs & ~s_chan;
   assign take_i  = hs & s_chan;

   assign sum_v    = acc_v + (take_v ? ACC_W'(s_data) : '0);
   assign sum_i    = acc_i + (take_i ? ACC_W'(s_data) : '0);
   assign cnt_v_nx = cnt_v + CNT_W'(take_v);
   assign cnt_i_nx = cnt_i + CNT_W'(take_i);
   assign done     = hs && (cnt_v_nx == FULL_CNT) && (cnt_i_nx == FULL_CNT);

   assign prod = {{SAMPLE_W{1'b0}}, avg_v} * {{SAMPLE_W{1'b0}}, avg_i};

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= ACCUM;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ACCUM:   if (done) state_nx = MUL;
         MUL:     state_nx = ACCUM;
         default: state_nx = ACCUM;
      endcase
   end

`ifdef SOLAR_AVG_MINMAX_EN
   logic [SAMPLE_W-1:0] min_v, max_v, min_nx, max_nx, lat_min, lat_max;

   // trackers restart on the first voltage sample of each window
   always_comb begin
      min_nx = min_v;
      max_nx = max_v;
      if (take_v) begin
         if (cnt_v == '0) begin
            min_nx = s_data;
            max_nx = s_data;
         end else begin
            if (s_data < min_v) min_nx = s_data;
            if (s_data > max_v) max_nx = s_data;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         min_v   <= '0;
         max_v   <= '0;
         lat_min <= '0;
         lat_max <= '0;
         m_min_v <= '0;
         m_max_v <= '0;
      end else begin
         min_v <= min_nx;
         max_v <= max_nx;
         if (done) begin
            lat_min <= min_nx;
            lat_max <= max_nx;
         end
         if (state == MUL) begin
            m_min_v <= lat_min;
            m_max_v <= lat_max;
         end
      end
   end
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         acc_v   <= '0;
         acc_i   <= '0;
         cnt_v   <= '0;
         cnt_i   <= '0;
         avg_v   <= '0;
         avg_i   <= '0;
         m_valid <= 1'b0;
         m_avg_v <= '0;
         m_avg_i <= '0;
         m_power <= '0;
         ovf     <= 1'b0;
      end else begin
         if (done) begin
            avg_v <= sum_v[ACC_W-1:LOG2_AVG];
            avg_i <= sum_i[ACC_W-1:LOG2_AVG];
            acc_v <= '0;
            acc_i <= '0;
            cnt_v <= '0;
            cnt_i <= '0;
         end else begin
            acc_v <= sum_v;
            acc_i <= sum_i;
            cnt_v <= cnt_v_nx;
            cnt_i <= cnt_i_nx;
         end

         if (state == MUL) begin
            m_valid <= 1'b1;
            m_avg_v <= avg_v;
            m_avg_i <= avg_i;
            m_power <= prod;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end

         // an unconsumed record being replaced sets ovf; set beats clear
         if (state == MUL && m_valid && !m_ready) ovf <= 1'b1;
         else if (clr_ovf)                        ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_solar_sample_averager.sv
// Directed self-checking bench for solar_sample_averager with hand-computed expected records.
module tb_solar_sample_averager;
   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        s_chan = 1'b0;
   logic [11:0] s_data = '0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [11:0] m_avg_v, m_avg_i;
   logic [23:0] m_power;
   logic        ovf;
   logic        clr_ovf = 1'b0;
`ifdef SOLAR_AVG_MINMAX_EN
   logic [11:0] m_min_v, m_max_v;
`endif

   int total = 0;
   int bad = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   solar_sample_averager #(.SAMPLE_W(12), .LOG2_AVG(4)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_avg_v(m_avg_v), .m_avg_i(m_avg_i), .m_power(m_power),
`ifdef SOLAR_AVG_MINMAX_EN
      .m_min_v(m_min_v), .m_max_v(m_max_v),
`endif
      .ovf(ovf), .clr_ovf(clr_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // present one sample, wait (bounded) for acceptance, return at the following negedge
   task automatic push(input logic ch, input logic [11:0] d);
      int n = 0;
      s_valid = 1'b1; s_chan = ch; s_data = d;
      #1;
      while (!s_ready && n < 40) begin
         @(negedge wb_clk_i); #1; n++;
      end
      if (n == 40) begin
         total++; bad++;
         $error("FAIL push_timeout observed=%0d expected=%0d", n, 0);
      end
      @(posedge wb_clk_i); #1;
      s_valid = 1'b0;
      @(negedge wb_clk_i);
   endtask

   task automatic win(input logic [11:0] v, input logic [11:0] i);
      for (int k = 0; k < 16; k++) begin
         push(1'b0, v);
         push(1'b1, i);
      end
   endtask

   task automatic rec(input string tag, input logic [11:0] v, input logic [11:0] i, input logic [23:0] p);
      @(negedge wb_clk_i);
      chk({tag, "_valid"}, m_valid, 1);
      chk({tag, "_avg_v"}, m_avg_v, v);
      chk({tag, "_avg_i"}, m_avg_i, i);
      chk({tag, "_power"}, m_power, p);
   endtask

   initial begin
      @(negedge wb_clk_i);
      @(negedge wb_clk_i);
      chk("rst_valid", m_valid, 0);
      chk("rst_avg_v", m_avg_v, 0);
      chk("rst_avg_i", m_avg_i, 0);
      chk("rst_power", m_power, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_ready", s_ready, 1);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);

      // constant window, one-cycle latency after the last handshake
      win(12'd100, 12'd50);
      chk("const_mul_valid", m_valid, 0);
      chk("const_mul_ready", s_ready, 0);
      rec("const", 12'd100, 12'd50, 24'd5000);
      @(negedge wb_clk_i);
      chk("const_consumed", m_valid, 0);

      // truncation and full scale
      for (int k = 0; k < 16; k++) begin
         push(1'b0, 12'(k));
         push(1'b1, 12'd4095);
      end
      rec("trunc", 12'd7, 12'd4095, 24'd28665);
      win(12'd4095, 12'd4095);
      rec("fullscale", 12'd4095, 12'd4095, 24'd16769025);

      // stall on full voltage channel
      for (int k = 0; k < 16; k++) push(1'b0, 12'd100);
      s_valid = 1'b1; s_chan = 1'b0; s_data = 12'd77;
      #1;
      chk("stall_v_ready", s_ready, 0);
      s_chan = 1'b1;
      #1;
      chk("stall_i_ready", s_ready, 1);
      s_valid = 1'b0;
      for (int k = 0; k < 16; k++) push(1'b1, 12'd10);
      rec("stall", 12'd100, 12'd10, 24'd1000);
      push(1'b0, 12'd77);
      for (int k = 0; k < 15; k++) push(1'b0, 12'd1);
      s_valid = 1'b1; s_chan = 1'b0; s_data = 12'd1;
      #1;
      chk("held_is_first", s_ready, 0);
      s_valid = 1'b0;
      for (int k = 0; k < 16; k++) push(1'b1, 12'd2);
      rec("held", 12'd5, 12'd2, 24'd10);
      @(negedge wb_clk_i);

      // overwrite, with clear arriving in the same cycle as a set
      m_ready = 1'b0;
      win(12'd10, 12'd10);
      rec("ovw_a", 12'd10, 12'd10, 24'd100);
      chk("ovw_a_ovf", ovf, 0);
      win(12'd20, 12'd30);
      clr_ovf = 1'b1;
      rec("ovw_b", 12'd20, 12'd30, 24'd600);
      clr_ovf = 1'b0;
      chk("ovw_set_wins", ovf, 1);
      @(negedge wb_clk_i);
      chk("ovw_hold", m_avg_v, 20);
      clr_ovf = 1'b1;
      @(negedge wb_clk_i);
      clr_ovf = 1'b0;
      chk("ovw_clr", ovf, 0);
      win(12'd40, 12'd2);
      m_ready = 1'b1;
      rec("ovw_c", 12'd40, 12'd2, 24'd80);
      chk("ovw_c_ovf", ovf, 0);
      @(negedge wb_clk_i);
      chk("ovw_c_consumed", m_valid, 0);

      // reset mid-window discards partial sums
      for (int k = 0; k < 10; k++) begin
         push(1'b0, 12'd200);
         push(1'b1, 12'd200);
      end
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      win(12'd300, 12'd300);
      rec("midrst", 12'd300, 12'd300, 24'd90000);
      @(negedge wb_clk_i);

      // reset during MUL yields no record
      win(12'd7, 12'd7);
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      @(negedge wb_clk_i);
      chk("mulrst_valid", m_valid, 0);
      chk("mulrst_avg_v", m_avg_v, 0);

`ifdef SOLAR_AVG_MINMAX_EN
      chk("mm_rst_min", m_min_v, 0);
      for (int k = 0; k < 16; k++) begin
         push(1'b0, (k == 0) ? 12'd5 : (k == 1) ? 12'd900 : (k == 2) ? 12'd17 : 12'd100);
         push(1'b1, 12'd1);
      end
      @(negedge wb_clk_i);
      chk("mm_min", m_min_v, 5);
      chk("mm_max", m_max_v, 900);
      win(12'd50, 12'd1);
      @(negedge wb_clk_i);
      chk("mm2_min", m_min_v, 50);
      chk("mm2_max", m_max_v, 50);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
